// File: rtl/vreg_file_mv_if.sv
// Decode-side bus of the vector register file: read/write addresses, data, mask and clear control.
interface vreg_file_mv_if #(
  parameter int unsigned LANES = 16,
  parameter int unsigned LANEW = 8,
  parameter int unsigned AW    = 4
);
  logic                     clr;
  logic                     busy;
  logic [AW-1:0]            ra1;
  logic [AW-1:0]            ra2;
  logic [LANES*LANEW-1:0]   rd1;
  logic [LANES*LANEW-1:0]   rd2;
  logic                     we3;
  logic [AW-1:0]            wa3;
  logic [LANES*LANEW-1:0]   wd3;
  logic [LANES-1:0]         wmask;

  modport master (
    output clr, ra1, ra2, we3, wa3, wd3, wmask,
    input  busy, rd1, rd2
  );

  modport slave (
    input  clr, ra1, ra2, we3, wa3, wd3, wmask,
    output busy, rd1, rd2
  );
endinterface

// File: rtl/vreg_file_mv.sv
// Parametrised SIMD vector register file: masked lane writes, registered read ports
// with write-through bypass, and a hardware zeroing sweep after reset or on clr.
module vreg_file_mv #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned LANES = 16,
  parameter int unsigned LANEW = 8,
  parameter int unsigned AW    = 4
) (
  input  logic           clk,
  input  logic           rst,
  vreg_file_mv_if.slave  bus
);
  localparam int unsigned DW       = LANES * LANEW;
  localparam logic [AW:0] NREGS_W  = (AW+1)'(NREGS);
  localparam logic [AW-1:0] LAST   = AW'(NREGS - 1);

  typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [DW-1:0]    rd1_q, rd1_d;
  logic [DW-1:0]    rd2_q, rd2_d;
  logic [DW-1:0]    mem_q [NREGS];
  logic [DW-1:0]    mem_d [NREGS];

  logic             wr_ok, rd1_ok, rd2_ok;
  logic [DW-1:0]    wr_old, wr_new;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [LANES-1:0] m);
    logic [DW-1:0] r;
    r = old_v;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (m[i]) r[i*LANEW +: LANEW] = new_v[i*LANEW +: LANEW];
    end
    return r;
  endfunction

  // Address qualification and the merged write value shared by storage and bypass.
  always_comb begin
    wr_ok  = bus.we3 && ({1'b0, bus.wa3} < NREGS_W);
    rd1_ok = {1'b0, bus.ra1} < NREGS_W;
    rd2_ok = {1'b0, bus.ra2} < NREGS_W;
    wr_old = wr_ok ? mem_q[bus.wa3] : '0;
    wr_new = merge(wr_old, bus.wd3, bus.wmask);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    rd1_d   = '0;
    rd2_d   = '0;
    mem_d   = mem_q;

    case (state_q)
      ST_CLEAR: begin
        mem_d[cnt_q] = '0;
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      ST_IDLE: begin
        // clr beats a same-cycle write; reads are zeroed so nothing leaks while busy.
        if (bus.clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else begin
          if (wr_ok) mem_d[bus.wa3] = wr_new;
          if (rd1_ok) rd1_d = (wr_ok && bus.wa3 == bus.ra1) ? wr_new : mem_q[bus.ra1];
          if (rd2_ok) rd2_d = (wr_ok && bus.wa3 == bus.ra2) ? wr_new : mem_q[bus.ra2];
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
        busy_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      rd1_q   <= '0;
      rd2_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      mem_q   <= mem_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.rd1  = rd1_q;
  assign bus.rd2  = rd2_q;
endmodule

// File: tb/tb_vreg_file_mv.sv
// Directed bench for vreg_file_mv: reference model feeds a scoreboard of expected read data;
// a second instance with NREGS=12 covers out-of-range addressing.
module tb_vreg_file_mv;
  localparam int unsigned LANES = 16;
  localparam int unsigned LANEW = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = LANES * LANEW;
  localparam int unsigned NR    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vreg_file_mv_if #(.LANES(LANES), .LANEW(LANEW), .AW(AW)) b16 ();
  vreg_file_mv_if #(.LANES(LANES), .LANEW(LANEW), .AW(AW)) b12 ();

  vreg_file_mv #(.NREGS(16), .LANES(LANES), .LANEW(LANEW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .bus(b16));
  vreg_file_mv #(.NREGS(12), .LANES(LANES), .LANEW(LANEW), .AW(AW)) dut12 (
    .clk(clk), .rst(rst), .bus(b12));

  assign b12.clr   = b16.clr;
  assign b12.ra1   = b16.ra1;
  assign b12.ra2   = b16.ra2;
  assign b12.we3   = b16.we3;
  assign b12.wa3   = b16.wa3;
  assign b12.wd3   = b16.wd3;
  assign b12.wmask = b16.wmask;

  int n_chk  = 0;
  int n_fail = 0;

  logic [DW-1:0]   mem [NR];
  bit              m_clear = 1'b1;
  int              m_cnt   = 0;
  logic [2*DW-1:0] sb [$];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                               input logic [LANES-1:0] m);
    logic [DW-1:0] r;
    for (int i = 0; i < int'(LANES); i++)
      r[i*LANEW +: LANEW] = m[i] ? n[i*LANEW +: LANEW] : o[i*LANEW +: LANEW];
    return r;
  endfunction

  // One clock: predict read data from the model, advance the model, then compare.
  task automatic step(input bit chk_rd);
    logic [DW-1:0]   e1, e2, nw;
    logic [2*DW-1:0] got;
    bit              wok;
    wok = b16.we3 && (int'(b16.wa3) < int'(NR));
    nw  = lane_merge(mem[b16.wa3], b16.wd3, b16.wmask);
    if (rst || m_clear || b16.clr) begin
      e1 = '0;
      e2 = '0;
    end else begin
      e1 = (wok && b16.wa3 == b16.ra1) ? nw : mem[b16.ra1];
      e2 = (wok && b16.wa3 == b16.ra2) ? nw : mem[b16.ra2];
    end
    if (chk_rd) sb.push_back({e1, e2});
    if (rst) begin
      m_clear = 1'b1;
      m_cnt   = 0;
    end else if (m_clear) begin
      mem[m_cnt] = '0;
      if (m_cnt == int'(NR) - 1) m_clear = 1'b0;
      else m_cnt++;
    end else if (b16.clr) begin
      m_clear = 1'b1;
      m_cnt   = 0;
    end else if (wok) begin
      mem[b16.wa3] = nw;
    end
    @(posedge clk);
    #1;
    check("busy", DW'(b16.busy), DW'(m_clear));
    if (chk_rd) begin
      got = sb.pop_front();
      check("rd1", b16.rd1, got[2*DW-1:DW]);
      check("rd2", b16.rd2, got[DW-1:0]);
    end
  endtask

  task automatic drive(input bit c, input bit we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [LANES-1:0] m,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    b16.clr = c; b16.we3 = we; b16.wa3 = wa; b16.wd3 = wd; b16.wmask = m;
    b16.ra1 = r1; b16.ra2 = r2;
  endtask

  logic [DW-1:0] ramp, aa, lane7f, ones, masked;

  initial begin
    for (int i = 0; i < int'(LANES); i++) ramp[i*LANEW +: LANEW] = LANEW'(i);
    aa     = {LANES{8'hAA}};
    ones   = '1;
    lane7f = DW'(8'h7F);
    masked = ramp;
    for (int i = 4; i < 8; i++) masked[i*LANEW +: LANEW] = 8'hAA;
    for (int i = 0; i < int'(NR); i++) mem[i] = 'x;

    drive(0, 0, 0, '0, '0, 0, 0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;

    // Reset sweep: 16 cycles on the default instance, 12 on the small one.
    for (int k = 1; k <= 16; k++) begin
      drive(0, 1, AW'(k), ones, '1, 0, 0);
      step(1);
      if (k == 11) check("busy12_k11", DW'(b12.busy), DW'(1'b1));
      if (k == 12) check("busy12_k12", DW'(b12.busy), DW'(1'b0));
    end

    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, '0, '0, AW'(i), AW'(15 - i));
      step(1);
    end

    drive(0, 1, 3, ramp, 16'hFFFF, 0, 0); step(1);
    drive(0, 0, 0, '0, '0, 3, 3);          step(1);
    check("full_wr_const", b16.rd1, ramp);

    drive(0, 1, 3, aa, 16'h00F0, 0, 0);    step(1);
    drive(0, 0, 0, '0, '0, 3, 0);          step(1);
    check("masked_wr_const", b16.rd1, masked);

    drive(0, 1, 5, lane7f, 16'h0001, 5, 5); step(1);
    check("bypass1_const", b16.rd1, lane7f);
    check("bypass2_const", b16.rd2, lane7f);
    drive(0, 0, 0, '0, '0, 5, 3);          step(1);

    // clr with a simultaneous write: write dropped, sweep ignores we3.
    drive(1, 1, 2, ones, '1, 2, 2);        step(1);
    for (int k = 0; k < 16; k++) begin
      drive(0, k[0], 2, ones, '1, 3, 2);
      step(1);
    end
    drive(0, 0, 0, '0, '0, 2, 3);          step(1);
    check("clr_drop_const", b16.rd1, '0);

    // Out-of-range on the 12-register instance.
    drive(0, 1, 15, ones, '1, 15, 11);     step(1);
    check("oor12_byp", b12.rd1, '0);
    check("oor12_rd2", b12.rd2, '0);
    drive(0, 0, 0, '0, '0, 15, 11);        step(1);
    check("oor12_rd1", b12.rd1, '0);
    check("oor12_r11", b12.rd2, '0);
    check("r15_16", b16.rd1, ones);
    drive(0, 1, 11, ramp, '1, 0, 0);       step(1);
    drive(0, 0, 0, '0, '0, 0, 11);         step(1);
    check("last12_rd2", b12.rd2, ramp);

    // Reset seven cycles into a sweep restarts it.
    drive(1, 0, 0, '0, '0, 3, 15);         step(1);
    drive(0, 0, 0, '0, '0, 3, 15);
    for (int k = 0; k < 7; k++) step(1);
    rst = 1'b1; step(1); rst = 1'b0;
    for (int k = 0; k < 16; k++) step(1);
    check("busy_end", DW'(b16.busy), DW'(1'b0));
    step(1);
    check("post_rst_rd2", b16.rd2, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vreg_file_mv.md
Name: vreg_file_mv

Overview:
- Parametrised vector register file for the SIMD FIR datapath; successor to the fixed 15x16x8 vector register file.
- Generalises register count, lane count and lane width; adds per-lane write mask, registered read ports with write-through bypass, and a hardware clear sweep after reset or on request.
- Sits between the decode stage (addresses and control) and the vector ALU / memory writeback.

Parameters:
NREGS, 16, number of vector registers
LANES, 16, lanes per vector register
LANEW, 8, bits per lane
AW, 4, address width; must satisfy 2**AW >= NREGS

Ports:
clk  in  1  clock; all logic is rising-edge
rst  in  1  synchronous active-high reset
clr  in  1  one-cycle pulse; starts a clear sweep
busy  out  1  high while a clear sweep runs
ra1  in  AW  read address, port 1
ra2  in  AW  read address, port 2
rd1  out  LANES*LANEW  read data, port 1; lane i = rd1[i*LANEW +: LANEW]
rd2  out  LANES*LANEW  read data, port 2; same packing
we3  in  1  write enable
wa3  in  AW  write address
wd3  in  LANES*LANEW  write data; lane i = wd3[i*LANEW +: LANEW]
wmask  in  LANES  per-lane write enable; bit i gates lane i

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- FSM states: CLEAR and IDLE.
- Reset:
  - rst=1 forces state CLEAR, sweep counter 0, busy=1, rd1=rd2=0.
  - rst has priority over every other input.
  - rst asserted mid-sweep restarts the sweep from register 0.
- CLEAR state:
  - Each cycle writes all-zero to register[cnt], then increments cnt.
  - After register NREGS-1 is cleared, next state is IDLE and busy falls on that edge. A full sweep therefore holds busy high for exactly NREGS cycles.
  - we3 is ignored (dropped, not queued).
  - rd1 and rd2 are forced to 0 each cycle.
  - clr is ignored.
- IDLE state:
  - clr=1 enters CLEAR with cnt=0; busy=1 from the next cycle.
  - If clr and we3 are asserted in the same cycle, clr wins and the write is dropped.
- Write (IDLE, we3=1, wa3<NREGS):
  - At the clock edge, lanes with wmask[i]=1 take wd3 lane i.
  - Lanes with wmask[i]=0 keep their value.
  - wmask=0 leaves the register unchanged.
  - wa3>=NREGS: write ignored, no wrap-around.
- Read:
  - Synchronous, 1-cycle latency: rdN at cycle t+1 reflects raN sampled at t.
  - raN>=NREGS returns 0.
  - Both ports may read the same address.
- Bypass:
  - If we3=1, wa3==raN and wa3<NREGS in the same cycle, rdN (next cycle) returns the merged value.
  - Merged value: wd3 lane i where wmask[i]=1, otherwise the stored lane i.
  - Both ports bypass independently.
- Widths: no arithmetic on data; lanes are stored bit-exact. The counter is AW bits wide and stops at NREGS-1.
- Storage contents before the first sweep completes are don't-care. They are not observable, because reads return 0 while busy.

Test Plan:
- Reset then sweep: pulse rst for 1 cycle -> busy=1 for exactly 16 cycles, then 0. After that, reading any register 0..15 returns 128'h0.
- Full write and readback: we3=1, wa3=3, wmask=16'hFFFF, wd3=128'h0F0E..0100 (lane i = i). Next cycle ra1=3 -> rd1=128'h0F0E..0100 one cycle later.
- Masked write: reg 3 = lanes 0..15 values; write wd3 all 8'hAA with wmask=16'h00F0 -> lanes 4..7 = 8'hAA, all other lanes unchanged.
- Bypass: same cycle we3=1, wa3=5, wmask=16'h0001, wd3 lane0=8'h7F, ra1=ra2=5 (reg 5 = 0). Next cycle rd1=rd2 with lane0=8'h7F and other lanes 0.
- Clear priority and out-of-range: in IDLE, assert clr and we3 (wa3=2) together -> busy=1 and the write is dropped. After the sweep, reg 2 reads 0. Writing wa3=15 with NREGS=12 changes nothing; ra1=15 returns 0.
- Reset mid-sweep: rst at sweep cycle 7 -> counter restarts. busy stays high for 16 more cycles after rst deasserts; rd1=0 throughout.
